alu_cmd_unit: RTL and testbench



---
 rtl/alu_cmd_unit.sv | 177 +++++++++++++++++
 tb/tb_alu_cmd_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_unit.sv
// -----------------------------------------------------------------------------
// alu_cmd_unit
//
// Handshaked command front-end for a small AND/OR/ADD/SUB ALU. A command is
// captured over a valid/ready port and executed in one registered stage. The
// result and its flags are then held on a valid/ready response port until the
// consumer takes them. Only one operation is in flight at a time, so peak
// throughput is one operation every three cycles.
//
// Optional feature (compile-time macro ALU_CMD_ACC_EN):
//   When defined, a WIDTH-bit accumulator is loaded with rsp_result on every
//   response handshake. A command with cmd_use_acc = 1 takes the accumulator
//   as operand a and ignores cmd_a. When undefined, there is no accumulator
//   and cmd_use_acc is ignored.
//
// Ports:
//   clk          rising-edge clock for all logic
//   rst_n        synchronous active-low reset
//   cmd_valid    command present
//   cmd_ready    unit can accept a command this cycle (IDLE and out of reset)
//   cmd_a        operand a
//   cmd_b        operand b
//   cmd_sel      operation: 00 AND, 01 OR, 10 ADD, 11 SUB
//   cmd_use_acc  take the accumulator as operand a (ALU_CMD_ACC_EN only)
//   rsp_valid    response present
//   rsp_ready    consumer accepts the response
//   rsp_result   operation result, wrapping modulo 2^WIDTH
//   rsp_carry    ADD carry out, SUB borrow (a < b unsigned), 0 for AND/OR
//   rsp_zero     rsp_result == 0
//   op_count     responses consumed since reset, wraps without a flag
// -----------------------------------------------------------------------------
module alu_cmd_unit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [1:0]       cmd_sel,
  input  logic             cmd_use_acc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [1:0]       sel_p0;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH:0]   alu_out;
  logic             cap_en;
  logic             exec_en;
  logic             rsp_hs;

  // Returns {carry, result}. For SUB the carry bit is the borrow, which is
  // the inverse of the natural carry out of a + ~b + 1.
  function automatic logic [WIDTH:0] alu_calc(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [1:0]       sel
  );
    logic [WIDTH:0] res;
    case (sel)
      2'b00:   res = {1'b0, a & b};
      2'b01:   res = {1'b0, a | b};
      2'b10:   res = {1'b0, a} + {1'b0, b};
      default: res = {(a < b), a + ~b + WIDTH'(1)};
    endcase
    return res;
  endfunction

`ifdef ALU_CMD_ACC_EN
  logic [WIDTH-1:0] acc;

  assign op_a = cmd_use_acc ? acc : cmd_a;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (rsp_hs) begin
      acc <= rsp_result;
    end
  end
`else
  logic unused_use_acc;

  assign unused_use_acc = cmd_use_acc;
  assign op_a           = cmd_a;
`endif

  assign cmd_ready = (state == IDLE) && rst_n;
  assign alu_out   = alu_calc(a_p0, b_p0, sel_p0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cap_en   = 1'b0;
    exec_en  = 1'b0;
    rsp_hs   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          cap_en   = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC: begin
        exec_en  = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        if (rsp_valid && rsp_ready) begin
          rsp_hs   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: operand capture on the command handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_p0   <= '0;
      b_p0   <= '0;
      sel_p0 <= '0;
    end else if (cap_en) begin
      a_p0   <= op_a;
      b_p0   <= cmd_b;
      sel_p0 <= cmd_sel;
    end
  end

  // Stage p1: execute into the response registers, hold until consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      op_count   <= '0;
    end else begin
      if (exec_en) begin
        rsp_result <= alu_out[WIDTH-1:0];
        rsp_carry  <= alu_out[WIDTH];
        rsp_zero   <= (alu_out[WIDTH-1:0] == '0);
        rsp_valid  <= 1'b1;
      end
      if (rsp_hs) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_unit.sv
module tb_alu_cmd_unit;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_sel;
  logic       cmd_use_acc;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;
  logic [7:0] op_count;

  int         checks;
  int         errors;
  logic [7:0] exp_count;

  alu_cmd_unit #(.WIDTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_sel    (cmd_sel),
    .cmd_use_acc(cmd_use_acc),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a command and returns just after the edge that captured it.
  task automatic issue(input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] sel, input logic ua);
    int n;
    cmd_a       = a;
    cmd_b       = b;
    cmd_sel     = sel;
    cmd_use_acc = ua;
    cmd_valid   = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    tick();
    cmd_valid   = 1'b0;
    cmd_use_acc = 1'b0;
  endtask

  // Returns in the first cycle in which rsp_valid is visible.
  task automatic wait_rsp();
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_a     = 4'hF;
    cmd_b     = 4'hF;
    cmd_sel   = 2'b10;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready);
    end
    tick();
    tick();
    checks++;
    if ({rsp_valid, rsp_result, rsp_carry, rsp_zero} !== 7'b0 || op_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b result=%b carry=%b zero=%b count=%0d required all 0",
               rsp_valid, rsp_result, rsp_carry, rsp_zero, op_count);
    end
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", cmd_ready);
    end
    exp_count = 8'd0;
  endtask

  task automatic test_and_or();
    rsp_ready = 1'b1;
    issue(4'b0101, 4'b0011, 2'b00, 1'b0);
    wait_rsp();
    checks++;
    if (rsp_result !== 4'b0001 || rsp_carry !== 1'b0 || rsp_zero !== 1'b0) begin
      errors++;
      $display("FAIL and_op: result=%b carry=%b zero=%b required 0001 0 0",
               rsp_result, rsp_carry, rsp_zero);
    end
    tick();
    exp_count++;
    issue(4'b0101, 4'b0011, 2'b01, 1'b0);
    wait_rsp();
    checks++;
    if (rsp_result !== 4'b0111 || rsp_carry !== 1'b0 || rsp_zero !== 1'b0) begin
      errors++;
      $display("FAIL or_op: result=%b carry=%b zero=%b required 0111 0 0",
               rsp_result, rsp_carry, rsp_zero);
    end
    tick();
    exp_count++;
    checks++;
    if (op_count !== 8'd2) begin
      errors++;
      $display("FAIL and_or_count: got %0d required 2", op_count);
    end
  endtask

  task automatic test_add_overflow();
    rsp_ready = 1'b1;
    issue(4'b1111, 4'b0001, 2'b10, 1'b0);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_latency_early: rsp_valid=%b required 0 one cycle after capture", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_latency: rsp_valid=%b required 1 two cycles after handshake", rsp_valid);
    end
    checks++;
    if (rsp_result !== 4'b0000 || rsp_carry !== 1'b1 || rsp_zero !== 1'b1) begin
      errors++;
      $display("FAIL add_overflow: result=%b carry=%b zero=%b required 0000 1 1",
               rsp_result, rsp_carry, rsp_zero);
    end
    tick();
    exp_count++;
  endtask

  task automatic test_sub();
    rsp_ready = 1'b1;
    issue(4'b0101, 4'b0011, 2'b11, 1'b0);
    wait_rsp();
    checks++;
    if (rsp_result !== 4'b0010 || rsp_carry !== 1'b0 || rsp_zero !== 1'b0) begin
      errors++;
      $display("FAIL sub_pos: result=%b carry=%b zero=%b required 0010 0 0",
               rsp_result, rsp_carry, rsp_zero);
    end
    tick();
    exp_count++;
    issue(4'b0011, 4'b0101, 2'b11, 1'b0);
    wait_rsp();
    checks++;
    if (rsp_result !== 4'b1110 || rsp_carry !== 1'b1 || rsp_zero !== 1'b0) begin
      errors++;
      $display("FAIL sub_neg: result=%b carry=%b zero=%b required 1110 1 0",
               rsp_result, rsp_carry, rsp_zero);
    end
    tick();
    exp_count++;
  endtask

  task automatic test_backpressure();
    logic bad;
    rsp_ready = 1'b0;
    issue(4'b0110, 4'b0011, 2'b10, 1'b0);
    wait_rsp();
    cmd_a     = 4'b0001;
    cmd_b     = 4'b0001;
    cmd_sel   = 2'b10;
    cmd_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_result !== 4'b1001 || rsp_carry !== 1'b0 ||
          rsp_zero !== 1'b0 || cmd_ready !== 1'b0 || op_count !== exp_count) begin
        bad = 1'b1;
        $display("FAIL bp_hold_%0d: valid=%b result=%b carry=%b zero=%b ready=%b count=%0d required 1 1001 0 0 0 %0d",
                 i, rsp_valid, rsp_result, rsp_carry, rsp_zero, cmd_ready, op_count, exp_count);
      end
    end
    checks++;
    if (bad) errors++;
    rsp_ready = 1'b1;
    tick();
    exp_count++;
    checks++;
    if (rsp_valid !== 1'b0 || op_count !== exp_count || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b count=%0d ready=%b required 0 %0d 1",
               rsp_valid, op_count, cmd_ready, exp_count);
    end
    tick();
    cmd_valid = 1'b0;
    wait_rsp();
    checks++;
    if (rsp_result !== 4'b0010 || rsp_carry !== 1'b0) begin
      errors++;
      $display("FAIL bp_held_cmd: result=%b carry=%b required 0010 0", rsp_result, rsp_carry);
    end
    tick();
    exp_count++;
  endtask

  task automatic test_reset_mid_op();
    logic bad;
    rsp_ready = 1'b1;
    issue(4'b0101, 4'b0011, 2'b00, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready: got %b required 0", cmd_ready);
    end
    tick();
    exp_count = 8'd0;
    checks++;
    if (rsp_valid !== 1'b0 || op_count !== 8'd0 || rsp_result !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_outputs: valid=%b count=%0d result=%b required 0 0 0000",
               rsp_valid, op_count, rsp_result);
    end
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midrst_no_rsp: valid=%b ready=%b required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_acc();
    rsp_ready = 1'b1;
    issue(4'b0101, 4'b0011, 2'b11, 1'b0);
    wait_rsp();
    checks++;
    if (rsp_result !== 4'b0010 || rsp_carry !== 1'b0) begin
      errors++;
      $display("FAIL acc_seed: result=%b carry=%b required 0010 0", rsp_result, rsp_carry);
    end
    tick();
    exp_count++;
    issue(4'b1111, 4'b0011, 2'b10, 1'b1);
    wait_rsp();
`ifdef ALU_CMD_ACC_EN
    checks++;
    if (rsp_result !== 4'b0101 || rsp_carry !== 1'b0) begin
      errors++;
      $display("FAIL acc_use: result=%b carry=%b required 0101 0", rsp_result, rsp_carry);
    end
`else
    checks++;
    if (rsp_result !== 4'b0010 || rsp_carry !== 1'b1) begin
      errors++;
      $display("FAIL acc_ignored: result=%b carry=%b required 0010 1", rsp_result, rsp_carry);
    end
`endif
    tick();
    exp_count++;
    checks++;
    if (op_count !== 8'd2) begin
      errors++;
      $display("FAIL acc_count: got %0d required 2", op_count);
    end
  endtask

  task automatic test_count_wrap();
    rsp_ready = 1'b1;
    while (exp_count != 8'hFF) begin
      issue(4'b0001, 4'b0001, 2'b00, 1'b0);
      wait_rsp();
      tick();
      exp_count++;
    end
    checks++;
    if (op_count !== 8'hFF) begin
      errors++;
      $display("FAIL count_max: got %0d required 255", op_count);
    end
    issue(4'b0001, 4'b0001, 2'b00, 1'b0);
    wait_rsp();
    tick();
    exp_count++;
    checks++;
    if (op_count !== 8'h00) begin
      errors++;
      $display("FAIL count_wrap: got %0d required 0", op_count);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    exp_count   = 8'd0;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_a       = 4'h0;
    cmd_b       = 4'h0;
    cmd_sel     = 2'b00;
    cmd_use_acc = 1'b0;
    rsp_ready   = 1'b0;
    tick();
    test_reset();
    test_and_or();
    test_add_overflow();
    test_sub();
    test_backpressure();
    test_reset_mid_op();
    test_acc();
    test_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
